// File: rtl/regfile_wb_ctrl.sv
// Writeback arbiter for the register file write port: ALU results and in-order load returns,
// with load queue, busy scoreboard and issue hazards. Optional REGFILE_WB_STATS_EN adds stall_count.
`timescale 1ns/1ps
module regfile_wb_ctrl #(
  parameter int LDQ_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        alu_wb_valid,
  output logic        alu_wb_ready,
  input  logic [2:0]  alu_wb_dr,
  input  logic [15:0] alu_wb_data,
  input  logic        ld_issue_valid,
  output logic        ld_issue_ready,
  input  logic [2:0]  ld_issue_dr,
  input  logic        ld_issue_d8,
  input  logic        mem_rsp_valid,
  input  logic [15:0] mem_rsp_data,
  input  logic [2:0]  src1_sel,
  input  logic [2:0]  src2_sel,
  output logic        src_hazard,
  output logic        write_en,
  output logic [2:0]  dr,
  output logic        alu_mem,
  output logic        d8_d16,
  output logic [15:0] rf_aluout,
  output logic [15:0] rf_mdr16,
  output logic        ldq_err
`ifdef REGFILE_WB_STATS_EN
  , output logic [15:0] stall_count
`endif
);

  localparam int PW = (LDQ_DEPTH > 1) ? $clog2(LDQ_DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [2:0]    ldq_dr [LDQ_DEPTH];
  logic          ldq_d8 [LDQ_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] ldq_count;
  logic [7:0]    busy, busy_nxt;
  logic          hold_valid;
  logic [2:0]    hold_dr;
  logic [15:0]   hold_data;

  logic ldq_empty, ldq_full, mem_wr, alu_acc, ld_acc;
  logic [2:0] head_dr;
  logic       head_d8;

  always_comb begin
    ldq_empty = (ldq_count == '0);
    ldq_full  = (ldq_count == CW'(LDQ_DEPTH));
    head_dr   = ldq_dr[rd_ptr];
    head_d8   = ldq_d8[rd_ptr];
    mem_wr    = mem_rsp_valid && !ldq_empty;
    alu_wb_ready = !hold_valid;
    // A response this cycle pops the head, so a full queue still has room for one issue.
    ld_issue_ready = (!ldq_full || mem_rsp_valid) && !busy[ld_issue_dr]
                     && !(hold_valid && (hold_dr == ld_issue_dr));
    alu_acc = alu_wb_valid && alu_wb_ready;
    ld_acc  = ld_issue_valid && ld_issue_ready;
    src_hazard = busy[src1_sel] || busy[src2_sel]
                 || (hold_valid && ((hold_dr == src1_sel) || (hold_dr == src2_sel)));
    busy_nxt = busy;
    if (mem_wr) busy_nxt[head_dr] = 1'b0;
    if (ld_acc) busy_nxt[ld_issue_dr] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (ld_acc && !reset) begin
      ldq_dr[wr_ptr] <= ld_issue_dr;
      ldq_d8[wr_ptr] <= ld_issue_d8;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ldq_count  <= '0;
      busy       <= '0;
      hold_valid <= 1'b0;
      hold_dr    <= '0;
      hold_data  <= '0;
      ldq_err    <= 1'b0;
      write_en   <= 1'b0;
      dr         <= '0;
      alu_mem    <= 1'b0;
      d8_d16     <= 1'b0;
      rf_aluout  <= '0;
      rf_mdr16   <= '0;
    end else begin
      if (ld_acc) wr_ptr <= wr_ptr + 1'b1;
      if (mem_wr) rd_ptr <= rd_ptr + 1'b1;
      case ({ld_acc, mem_wr})
        2'b10:   ldq_count <= ldq_count + 1'b1;
        2'b01:   ldq_count <= ldq_count - 1'b1;
        default: ldq_count <= ldq_count;
      endcase
      busy <= busy_nxt;
      if (mem_rsp_valid && ldq_empty) ldq_err <= 1'b1;

      write_en <= 1'b0;
      if (mem_wr) begin
        write_en <= 1'b1;
        dr       <= head_dr;
        alu_mem  <= 1'b0;
        d8_d16   <= head_d8;
        rf_mdr16 <= mem_rsp_data;
        if (alu_acc) begin
          hold_valid <= 1'b1;
          hold_dr    <= alu_wb_dr;
          hold_data  <= alu_wb_data;
        end
      end else if (hold_valid && !mem_rsp_valid) begin
        write_en   <= 1'b1;
        dr         <= hold_dr;
        alu_mem    <= 1'b1;
        d8_d16     <= 1'b0;
        rf_aluout  <= hold_data;
        hold_valid <= 1'b0;
      end else if (alu_acc) begin
        write_en  <= 1'b1;
        dr        <= alu_wb_dr;
        alu_mem   <= 1'b1;
        d8_d16    <= 1'b0;
        rf_aluout <= alu_wb_data;
      end
    end
  end

`ifdef REGFILE_WB_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) stall_count <= '0;
    else if (alu_wb_valid && !alu_wb_ready && (stall_count != 16'hFFFF))
      stall_count <= stall_count + 1'b1;
  end
`endif

endmodule
